// File: rtl/pipe_adder_if.sv
// Handshake and operand/result bundle for pipe_adder.
// Latency: none, pure wiring.
// Backpressure: in_ready/out_ready carry the valid-ready flow control both ways.
//
// master: operand source and result sink (drives operands, consumes results).
// slave : the adder itself.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co, ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract; each of STAGES segments resolved by 4-bit CLA groups.
// Latency: STAGES register stages, one accept per clock.
// Backpressure: whole pipeline freezes while out_valid & ~out_ready; in_ready = ~out_valid | out_ready.
//
// Ports: clk, reset_n (async active-low); io (slave): in_valid/in_ready, a, b, ci, sub,
//        out_valid/out_ready, s, co (carry of effective addition), ovf (signed overflow).
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    pipe_adder_if.slave io
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / 4;

    // Stage k forwards WIDTH-(k+1)*SEG unconsumed operand bits; all stages are
    // packed back to back into one flat skew vector per operand.
    localparam int SKEW_BITS = (STAGES - 1) * WIDTH - SEG * (STAGES - 1) * STAGES / 2;
    localparam int SKEW_W    = (SKEW_BITS > 0) ? SKEW_BITS : 1;
    // Stage k holds (k+1)*SEG finished sum bits, packed the same way.
    localparam int SUM_W     = SEG * STAGES * (STAGES + 1) / 2;

    logic              adv;
    logic              accept;
    logic [WIDTH-1:0]  b_eff;
    logic              c_in;
    logic [STAGES-1:0] vld_vec;
    logic [STAGES-1:0] cry_vec;
    logic [SKEW_W-1:0] a_skew;
    logic [SKEW_W-1:0] b_skew;
    logic [SUM_W-1:0]  sum_vec;
    logic              ovf_q;

    // One segment: NGRP lookahead groups, group carries ripple within the segment.
    // Returns {carry_out, sum}.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           cin);
        logic [SEG-1:0] sum;
        logic [3:0]     gp;
        logic [3:0]     gg;
        logic [4:1]     c;
        logic           cg;
        sum = '0;
        cg  = cin;
        for (int i = 0; i < NGRP; i++) begin
            gp   = x[4*i +: 4] ^ y[4*i +: 4];
            gg   = x[4*i +: 4] & y[4*i +: 4];
            c[1] = gg[0] | (gp[0] & cg);
            c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cg);
            c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cg);
            c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & cg);
            sum[4*i +: 4] = gp ^ {c[3:1], cg};
            cg = c[4];
        end
        return {cg, sum};
    endfunction

    assign adv         = ~vld_vec[STAGES-1] | io.out_ready;
    assign io.in_ready = adv;
    assign accept      = io.in_valid & adv;
    assign b_eff       = io.b ^ {WIDTH{io.sub}};
    assign c_in        = io.sub ? ~io.ci : io.ci;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int W_IN    = WIDTH - k * SEG;
        localparam int S_OUT   = (k + 1) * SEG;
        localparam int SUM_OFF = SEG * k * (k + 1) / 2;

        logic [W_IN-1:0]  in_a;
        logic [W_IN-1:0]  in_b;
        logic             in_c;
        logic             in_v;
        logic [SEG:0]     res;
        logic [S_OUT-1:0] sum_d;
        logic             vld_q;
        logic             cry_q;
        logic [S_OUT-1:0] sum_q;

        if (k == 0) begin : g_first
            assign in_a  = io.a;
            assign in_b  = b_eff;
            assign in_c  = c_in;
            assign in_v  = accept;
            assign sum_d = res[SEG-1:0];
        end else begin : g_next
            localparam int PREV_SK  = (k - 1) * WIDTH - SEG * (k - 1) * k / 2;
            localparam int PREV_SUM = SEG * (k - 1) * k / 2;
            assign in_a  = a_skew[PREV_SK +: W_IN];
            assign in_b  = b_skew[PREV_SK +: W_IN];
            assign in_c  = cry_vec[k-1];
            assign in_v  = vld_vec[k-1];
            assign sum_d = {res[SEG-1:0], sum_vec[PREV_SUM +: k*SEG]};
        end

        assign res = seg_add(in_a[SEG-1:0], in_b[SEG-1:0], in_c);

        // Data registers load on every advance, bubbles included; only vld_q
        // distinguishes real operations.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q <= 1'b0;
                cry_q <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= in_v;
                cry_q <= res[SEG];
                sum_q <= sum_d;
            end
        end

        assign vld_vec[k]                = vld_q;
        assign cry_vec[k]                = cry_q;
        assign sum_vec[SUM_OFF +: S_OUT] = sum_q;

        if (k < STAGES - 1) begin : g_skew
            localparam int SK_OFF = k * WIDTH - SEG * k * (k + 1) / 2;
            localparam int W_FWD  = W_IN - SEG;
            logic [W_FWD-1:0] a_q;
            logic [W_FWD-1:0] b_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= in_a[W_IN-1:SEG];
                    b_q <= in_b[W_IN-1:SEG];
                end
            end

            assign a_skew[SK_OFF +: W_FWD] = a_q;
            assign b_skew[SK_OFF +: W_FWD] = b_q;
        end else begin : g_last
            // Carry into the MSB is recovered from the MSB sum bit (s ^ a ^ b),
            // so the CLA function only has to export the segment carry-out.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= res[SEG] ^ (res[SEG-1] ^ in_a[SEG-1] ^ in_b[SEG-1]);
                end
            end
        end
    end

    assign io.out_valid = vld_vec[STAGES-1];
    assign io.s         = sum_vec[SUM_W-WIDTH +: WIDTH];
    assign io.co        = cry_vec[STAGES-1];
    assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed arithmetic, backpressure, resets,
// and a concurrent random sweep over four further (WIDTH, STAGES) configurations.
// Outputs are sampled 1 ns after the falling edge, inputs driven at the falling edge.
module tb_pipe_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   sweep_go = 1'b0;
    int   sweep_done_cnt = 0;

    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(32)) dif ();
    pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut (.clk(clk), .reset_n(rst_n), .io(dif));

    // Reference: exact integer arithmetic on w-bit operands. Returns {ovf, co, s}.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic ci,
                                            input logic sub);
        logic signed [67:0] ua, ub, c, u, sa, sb, r, lim;
        logic [63:0] mask, s;
        logic co, ovf;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        ua = {4'b0, a & mask};
        ub = {4'b0, b & mask};
        c  = {67'b0, ci};
        if (!sub) begin
            u  = ua + ub + c;
            co = (u >= (68'sd1 <<< w));
        end else begin
            u  = ua - ub - c;
            co = (u >= 0);
        end
        s   = u[63:0] & mask;
        sa  = a[w-1] ? ua - (68'sd1 <<< w) : ua;
        sb  = b[w-1] ? ub - (68'sd1 <<< w) : ub;
        r   = sub ? sa - sb - c : sa + sb + c;
        lim = 68'sd1 <<< (w - 1);
        ovf = (r >= lim) || (r < -lim);
        return {ovf, co, s};
    endfunction

    // Issue one operation into an idle pipeline with out_ready high and report
    // the first visible result and its latency in clock edges (accept edge = 1).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic sub, output logic [31:0] s, output logic co,
                          output logic ovf, output int lat);
        @(negedge clk);
        dif.in_valid = 1'b1; dif.a = a; dif.b = b; dif.ci = ci; dif.sub = sub;
        dif.out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        dif.in_valid = 1'b0;
        while (!dif.out_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        #1;
        s = dif.s; co = dif.co; ovf = dif.ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", dif.out_valid); end
        checks++; if (dif.s !== 32'd0) begin errors++; $display("FAIL reset_s got %h want 0", dif.s); end
        checks++; if (dif.co !== 1'b0) begin errors++; $display("FAIL reset_co got %b want 0", dif.co); end
        checks++; if (dif.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", dif.ovf); end
        checks++; if (dif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", dif.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta  [5] = '{32'hFFFF_FFFF, 32'd5, 32'd7, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] tbv [5] = '{32'd1, 32'd7, 32'd5, 32'd1, 32'd1};
        logic        tci [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        tsub[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] es  [5] = '{32'h0, 32'hFFFF_FFFE, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF};
        logic        eco [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        eovf[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] s;
        logic co, ovf;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tbv[i], tci[i], tsub[i], s, co, ovf, lat);
            checks++; if (lat != 4) begin errors++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
            checks++; if (s !== es[i]) begin errors++; $display("FAIL dir%0d_s got %h want %h", i, s, es[i]); end
            checks++; if (co !== eco[i]) begin errors++; $display("FAIL dir%0d_co got %b want %b", i, co, eco[i]); end
            checks++; if (ovf !== eovf[i]) begin errors++; $display("FAIL dir%0d_ovf got %b want %b", i, ovf, eovf[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] q[$];
        logic [33:0] e;
        logic [65:0] m;
        int issued = 0, got = 0, cyc = 0, stall_left = 0, extra = 0;
        bit stall_done = 0, holding = 0, acc, deq;
        while (got < 10 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (!holding) begin
                if (issued < 10) begin
                    dif.in_valid = 1'b1; dif.a = $urandom; dif.b = $urandom;
                    dif.ci = 1'($urandom_range(1)); dif.sub = 1'($urandom_range(1));
                end else begin
                    dif.in_valid = 1'b0;
                end
            end
            if (!stall_done && stall_left == 0 && got == 4 && dif.out_valid) stall_left = 3;
            dif.out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                checks++;
                if (!dif.out_valid || q.size() == 0 || {dif.ovf, dif.co, dif.s} !== q[0]) begin
                    errors++; $display("FAIL stall_hold got v=%b %h want v=1 %h", dif.out_valid, {dif.ovf, dif.co, dif.s}, (q.size() != 0) ? q[0] : 34'h0);
                end
                checks++; if (dif.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", dif.in_ready); end
                stall_left--;
                if (stall_left == 0) stall_done = 1;
            end
            acc = dif.in_valid & dif.in_ready;
            deq = dif.out_valid & dif.out_ready;
            if (deq) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_unexpected got result %h want none", dif.s);
                end else begin
                    e = q.pop_front();
                    if ({dif.ovf, dif.co, dif.s} !== e) begin errors++; $display("FAIL bp_result%0d got %h want %h", got, {dif.ovf, dif.co, dif.s}, e); end
                end
                got++;
            end
            if (acc) begin
                m = ref_add(32, 64'(dif.a), 64'(dif.b), dif.ci, dif.sub);
                q.push_back({m[65:64], m[31:0]});
                issued++;
            end
            holding = dif.in_valid & ~acc;
        end
        dif.in_valid = 1'b0;
        dif.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (dif.out_valid) extra++;
        end
        checks++; if (got != 10 || issued != 10) begin errors++; $display("FAIL bp_count got %0d/%0d want 10/10", got, issued); end
        checks++; if (!stall_done) begin errors++; $display("FAIL bp_stall_seen got 0 want 1"); end
        checks++; if (extra != 0) begin errors++; $display("FAIL bp_duplicate got %0d want 0", extra); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] s;
        logic co, ovf;
        logic [65:0] m;
        int lat, seen = 0;
        dif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dif.in_valid = 1'b1; dif.a = $urandom; dif.b = $urandom; dif.ci = 1'b0; dif.sub = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        dif.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (dif.out_valid !== 1'b0 || dif.s !== 32'd0 || dif.co !== 1'b0 || dif.ovf !== 1'b0) begin
            errors++; $display("FAIL midflight_reset_outputs got %b %h %b %b want 0 0 0 0", dif.out_valid, dif.s, dif.co, dif.ovf);
        end
        checks++; if (dif.in_ready !== 1'b1) begin errors++; $display("FAIL midflight_reset_in_ready got %b want 1", dif.in_ready); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (dif.out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midflight_ghost got %0d want 0", seen); end
        run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1, s, co, ovf, lat);
        m = ref_add(32, 64'h1234_5678, 64'h0FED_CBA9, 1'b1, 1'b1);
        checks++; if (lat != 4) begin errors++; $display("FAIL midflight_latency got %0d want 4", lat); end
        checks++; if ({ovf, co, s} !== {m[65:64], m[31:0]}) begin errors++; $display("FAIL midflight_result got %h want %h", {ovf, co, s}, {m[65:64], m[31:0]}); end
    endtask

    task automatic test_reset_async_hold();
        int lat = 0;
        @(negedge clk);
        dif.in_valid = 1'b1; dif.a = 32'h8000_0001; dif.b = 32'h8000_0001; dif.ci = 1'b0; dif.sub = 1'b0;
        dif.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dif.in_valid = 1'b0;
        while (!dif.out_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
        @(negedge clk); #1;
        checks++; if ({dif.out_valid, dif.ovf, dif.co, dif.s} !== {3'b111, 32'd2}) begin
            errors++; $display("FAIL hold_result got %b %b %b %h want 1 1 1 00000002", dif.out_valid, dif.ovf, dif.co, dif.s);
        end
        rst_n = 1'b0;
        #1;
        checks++; if ({dif.out_valid, dif.ovf, dif.co, dif.s} !== 35'd0) begin
            errors++; $display("FAIL async_clear got %b %b %b %h want all 0", dif.out_valid, dif.ovf, dif.co, dif.s);
        end
        checks++; if (dif.in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready got %b want 1", dif.in_ready); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dif.out_ready = 1'b1;
    endtask

    task automatic test_param_sweep();
        int cyc = 0;
        @(negedge clk);
        sweep_go = 1'b1;
        while (sweep_done_cnt < 4 && cyc < 30000) begin @(posedge clk); cyc++; end
        checks++; if (sweep_done_cnt != 4) begin errors++; $display("FAIL sweep_timeout got %0d done want 4", sweep_done_cnt); end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int SW = (gi == 2) ? 16 : (gi == 3) ? 64 : 32;
        localparam int SS = (gi == 0) ? 1 : (gi == 1) ? 8 : (gi == 2) ? 2 : 4;

        pipe_adder_if #(.WIDTH(SW)) sif ();
        pipe_adder #(.WIDTH(SW), .STAGES(SS)) u_dut (.clk(clk), .reset_n(rst_n), .io(sif));

        initial begin
            logic [SW+1:0] q[$];
            logic [SW+1:0] e;
            logic [65:0] m;
            int issued, got, cyc, lat;
            bit holding, acc, deq;
            sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.ci = 1'b0; sif.sub = 1'b0;
            sif.out_ready = 1'b1;
            wait (sweep_go);
            // latency probe on an empty pipeline
            @(negedge clk);
            sif.in_valid = 1'b1; sif.a = SW'({$urandom, $urandom}); sif.b = SW'({$urandom, $urandom});
            sif.ci = 1'b1; sif.sub = 1'b0;
            m = ref_add(SW, 64'(sif.a), 64'(sif.b), 1'b1, 1'b0);
            @(posedge clk);
            lat = 1;
            @(negedge clk);
            sif.in_valid = 1'b0;
            while (!sif.out_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
            #1;
            checks++; if (lat != SS) begin errors++; $display("FAIL sweep_w%0d_s%0d_latency got %0d want %0d", SW, SS, lat, SS); end
            checks++; if ({sif.ovf, sif.co, sif.s} !== {m[65:64], m[SW-1:0]}) begin
                errors++; $display("FAIL sweep_w%0d_s%0d_probe got %h want %h", SW, SS, {sif.ovf, sif.co, sif.s}, {m[65:64], m[SW-1:0]});
            end
            issued = 0; got = 0; cyc = 0; holding = 0;
            while ((issued < 1000 || got < issued) && cyc < 20000) begin
                @(negedge clk); cyc++;
                if (!holding) begin
                    if (issued < 1000 && $urandom_range(3) != 0) begin
                        sif.in_valid = 1'b1;
                        sif.a = SW'({$urandom, $urandom}); sif.b = SW'({$urandom, $urandom});
                        sif.ci = 1'($urandom_range(1)); sif.sub = 1'($urandom_range(1));
                    end else begin
                        sif.in_valid = 1'b0;
                    end
                end
                sif.out_ready = ($urandom_range(3) != 0);
                #1;
                acc = sif.in_valid & sif.in_ready;
                deq = sif.out_valid & sif.out_ready;
                if (deq) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++; $display("FAIL sweep_w%0d_s%0d_unexpected got %h want none", SW, SS, sif.s);
                    end else begin
                        e = q.pop_front();
                        if ({sif.ovf, sif.co, sif.s} !== e) begin
                            errors++; $display("FAIL sweep_w%0d_s%0d_op%0d got %h want %h", SW, SS, got, {sif.ovf, sif.co, sif.s}, e);
                        end
                    end
                    got++;
                end
                if (acc) begin
                    m = ref_add(SW, 64'(sif.a), 64'(sif.b), sif.ci, sif.sub);
                    q.push_back({m[65:64], m[SW-1:0]});
                    issued++;
                end
                holding = sif.in_valid & ~acc;
            end
            sif.in_valid = 1'b0;
            checks++; if (issued != 1000 || got != issued) begin
                errors++; $display("FAIL sweep_w%0d_s%0d_count got %0d/%0d want 1000/1000", SW, SS, got, issued);
            end
            sweep_done_cnt++;
        end
    end

    initial begin
        dif.in_valid = 1'b0; dif.a = '0; dif.b = '0; dif.ci = 1'b0; dif.sub = 1'b0;
        dif.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_reset_async_hold();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
